// File: rtl/udma_crc_check_pkg.sv
// rtl/udma_crc_check_pkg.sv - shared constants and state type for the UDMA CRC checker/generator
package udma_crc_check_pkg;

    // CRC register value loaded at the start of every burst
    localparam logic [15:0] UDMA_CRC_SEED = 16'h4ABA;

    // x^16 + x^12 + x^5 + 1, implicit x^16 term dropped
    localparam logic [15:0] UDMA_CRC_POLY = 16'h1021;

    // Default width of the optional mismatch counter
    localparam int UDMA_CRC_ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        CRC_ST_IDLE  = 2'd0,
        CRC_ST_ACCUM = 2'd1,
        CRC_ST_CHECK = 2'd2
    } udma_crc_state_e;

endpackage

// File: rtl/udma_crc_next.sv
// rtl/udma_crc_next.sv - combinational 16-bit-parallel CRC-CCITT next-state function
module udma_crc_next
    import udma_crc_check_pkg::*;
(
    input  logic [15:0] C,
    input  logic [15:0] D,
    output logic [15:0] Q
);

    logic [15:0] acc;

    // Unrolled MSB-first shift of all 16 data bits; collapses to one XOR network per output bit
    always_comb begin
        acc = C;
        for (int i = 15; i >= 0; i--) begin
            if (acc[15] ^ D[i]) begin
                acc = {acc[14:0], 1'b0} ^ UDMA_CRC_POLY;
            end else begin
                acc = {acc[14:0], 1'b0};
            end
        end
        Q = acc;
    end

endmodule

// File: rtl/udma_crc_check.sv
// rtl/udma_crc_check.sv - device-end UDMA burst CRC checker; optional ERR_CNT output under UDMA_CRC_ERRCNT_EN
module udma_crc_check
    import udma_crc_check_pkg::*;
#(
    parameter logic [15:0] SEED = UDMA_CRC_SEED
`ifdef UDMA_CRC_ERRCNT_EN
    ,
    parameter int ERR_CNT_W = UDMA_CRC_ERR_CNT_W
`endif
)
(
    input  logic        CLK4,
    input  logic        RST_N,
    input  logic        BURST_START,
    input  logic        WORD_VLD,
    input  logic [15:0] D,
    input  logic        CRC_VLD,
    input  logic [15:0] RX_CRC,
    input  logic        ERR_CLR,
    output logic        BUSY,
    output logic [15:0] CRC_CALC,
    output logic        CRC_DONE,
    output logic        CRC_OK,
    output logic        CRC_ERR
`ifdef UDMA_CRC_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

    localparam logic [1:0] IDLE  = CRC_ST_IDLE;
    localparam logic [1:0] ACCUM = CRC_ST_ACCUM;
    localparam logic [1:0] CHECK = CRC_ST_CHECK;

    logic [1:0]  state;
    logic [15:0] rx_crc_q;
    logic [15:0] crc_nxt;
    logic        mismatch;

    udma_crc_next u_next (
        .C (CRC_CALC),
        .D (D),
        .Q (crc_nxt)
    );

    assign BUSY     = (state == ACCUM);
    assign mismatch = (rx_crc_q != CRC_CALC);

    // Burst sequencing and CRC accumulation; a re-arm in ACCUM outranks CRC_VLD, which outranks WORD_VLD
    always_ff @(posedge CLK4 or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            CRC_CALC <= SEED;
            rx_crc_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (BURST_START) begin
                        CRC_CALC <= SEED;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (BURST_START) begin
                        CRC_CALC <= SEED;
                    end else if (CRC_VLD) begin
                        rx_crc_q <= RX_CRC;
                        state    <= CHECK;
                    end else if (WORD_VLD) begin
                        CRC_CALC <= crc_nxt;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Compare result, done pulse and sticky error; a mismatch set beats a coincident ERR_CLR
    always_ff @(posedge CLK4 or negedge RST_N) begin
        if (!RST_N) begin
            CRC_DONE <= 1'b0;
            CRC_OK   <= 1'b0;
            CRC_ERR  <= 1'b0;
        end else begin
            CRC_DONE <= (state == CHECK);
            if (state == CHECK) begin
                CRC_OK <= !mismatch;
            end else if (BURST_START && (state == IDLE || state == ACCUM)) begin
                CRC_OK <= 1'b0;
            end
            if (state == CHECK && mismatch) begin
                CRC_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                CRC_ERR <= 1'b0;
            end
        end
    end

`ifdef UDMA_CRC_ERRCNT_EN
    // Saturating mismatch counter; clear plus coincident mismatch leaves a count of one
    always_ff @(posedge CLK4 or negedge RST_N) begin
        if (!RST_N) begin
            ERR_CNT <= '0;
        end else if (state == CHECK && mismatch) begin
            if (ERR_CLR) begin
                ERR_CNT <= ERR_CNT_W'(1);
            end else if (ERR_CNT != {ERR_CNT_W{1'b1}}) begin
                ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
            end
        end else if (ERR_CLR) begin
            ERR_CNT <= '0;
        end
    end
`else
    // No mismatch counter in this build
`endif

endmodule

// File: tb/tb_udma_crc_check.sv
// tb/tb_udma_crc_check.sv - self-checking bench for udma_crc_check
module tb_udma_crc_check;

    localparam logic [15:0] SEED = 16'h4ABA;
`ifdef UDMA_CRC_ERRCNT_EN
    localparam int EW = 2;
`endif

    logic        CLK4 = 1'b0;
    logic        RST_N = 1'b0;
    logic        BURST_START = 1'b0;
    logic        WORD_VLD = 1'b0;
    logic [15:0] D = 16'h0;
    logic        CRC_VLD = 1'b0;
    logic [15:0] RX_CRC = 16'h0;
    logic        ERR_CLR = 1'b0;
    logic        BUSY;
    logic [15:0] CRC_CALC;
    logic        CRC_DONE;
    logic        CRC_OK;
    logic        CRC_ERR;
`ifdef UDMA_CRC_ERRCNT_EN
    logic [EW-1:0] ERR_CNT;
`endif

    bit clk_run = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic err_exp = 1'b0;
    logic [15:0] sbuf [0:299];

`ifdef UDMA_CRC_ERRCNT_EN
    udma_crc_check #(.SEED(SEED), .ERR_CNT_W(EW)) dut (
`else
    udma_crc_check #(.SEED(SEED)) dut (
`endif
        .CLK4(CLK4), .RST_N(RST_N), .BURST_START(BURST_START), .WORD_VLD(WORD_VLD),
        .D(D), .CRC_VLD(CRC_VLD), .RX_CRC(RX_CRC), .ERR_CLR(ERR_CLR), .BUSY(BUSY),
        .CRC_CALC(CRC_CALC), .CRC_DONE(CRC_DONE), .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR)
`ifdef UDMA_CRC_ERRCNT_EN
        , .ERR_CNT(ERR_CNT)
`endif
    );

    always begin
        #5;
        if (clk_run) CLK4 = ~CLK4;
    end

    always @(negedge CLK4) if (CRC_DONE === 1'b1) done_cnt++;

    // Remainder of (crc ^ word) * x^16 modulo the generator polynomial
    function automatic logic [15:0] gold(input logic [15:0] crc, input logic [15:0] w);
        logic [31:0] r;
        r = {crc ^ w, 16'h0000};
        for (int i = 31; i >= 16; i--)
            if (r[i]) r = r ^ (32'h0001_1021 << (i - 16));
        return r[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK4);
        #1;
    endtask

    task automatic run_burst(input string name, input int n, input logic [15:0] rx, input logic clr,
                             input logic [15:0] exp_calc, input logic exp_ok);
        BURST_START = 1'b1;
        tick();
        BURST_START = 1'b0;
        chk({name, ":busy"}, BUSY, 1);
        for (int i = 0; i < n; i++) begin
            WORD_VLD = 1'b1;
            D = sbuf[i];
            tick();
        end
        WORD_VLD = 1'b0;
        CRC_VLD = 1'b1;
        RX_CRC = rx;
        tick();
        CRC_VLD = 1'b0;
        chk({name, ":done_early"}, CRC_DONE, 0);
        chk({name, ":calc"}, CRC_CALC, exp_calc);
        ERR_CLR = clr;
        tick();
        ERR_CLR = 1'b0;
        err_exp = (err_exp & ~clr) | ~exp_ok;
        chk({name, ":done"}, CRC_DONE, 1);
        chk({name, ":ok"}, CRC_OK, exp_ok);
        chk({name, ":err"}, CRC_ERR, err_exp);
        chk({name, ":busy_after"}, BUSY, 0);
        tick();
        chk({name, ":done_pulse"}, CRC_DONE, 0);
        chk({name, ":ok_held"}, CRC_OK, exp_ok);
        chk({name, ":calc_held"}, CRC_CALC, exp_calc);
    endtask

    typedef struct {
        int          n;
        logic [15:0] base;
        logic [15:0] step;
        int          flip;
        logic [15:0] rx_xor;
        logic        clr;
        logic        exp_ok;
    } vec_t;

    initial begin
        vec_t vt [7];
        logic [15:0] g, s, w, rx;
        int n, d0;
        logic bad, clr;

        vt[0] = '{0,   16'h0000, 16'h0000, -1, 16'h0000, 1'b0, 1'b1};
        vt[1] = '{0,   16'h0000, 16'h0000, -1, 16'h0001, 1'b0, 1'b0};
        vt[2] = '{256, 16'h0000, 16'h0001, -1, 16'h0000, 1'b0, 1'b1};
        vt[3] = '{256, 16'h0000, 16'h0001, 37, 16'h0000, 1'b0, 1'b0};
        vt[4] = '{1,   16'hA5A5, 16'h0000, -1, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{8,   16'hFFFF, 16'h0000, -1, 16'h0000, 1'b0, 1'b1};
        vt[6] = '{4,   16'h1000, 16'h0101, -1, 16'h8000, 1'b1, 1'b0};

        // Reset state
        tick();
        chk("rst:busy", BUSY, 0);
        chk("rst:calc", CRC_CALC, SEED);
        chk("rst:done", CRC_DONE, 0);
        chk("rst:ok", CRC_OK, 0);
        chk("rst:err", CRC_ERR, 0);
        RST_N = 1'b1;
        tick();

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            g = SEED;
            s = SEED;
            for (int i = 0; i < vt[v].n; i++) begin
                w = 16'(vt[v].base + vt[v].step * i);
                g = gold(g, w);
                sbuf[i] = (i == vt[v].flip) ? (w ^ 16'h0001) : w;
                s = gold(s, sbuf[i]);
            end
            run_burst($sformatf("vec%0d", v), vt[v].n, g ^ vt[v].rx_xor, vt[v].clr, s, vt[v].exp_ok);
        end

        // Abort: second BURST_START restarts from seed, only one compare
        d0 = done_cnt;
        BURST_START = 1'b1;
        tick();
        BURST_START = 1'b0;
        for (int i = 0; i < 10; i++) begin
            WORD_VLD = 1'b1;
            D = 16'($urandom);
            tick();
        end
        WORD_VLD = 1'b0;
        BURST_START = 1'b1;
        tick();
        BURST_START = 1'b0;
        chk("abort:calc_seed", CRC_CALC, SEED);
        g = SEED;
        for (int i = 0; i < 5; i++) begin
            WORD_VLD = 1'b1;
            D = 16'hFFFF;
            g = gold(g, 16'hFFFF);
            tick();
        end
        WORD_VLD = 1'b0;
        CRC_VLD = 1'b1;
        RX_CRC = g;
        tick();
        CRC_VLD = 1'b0;
        tick();
        chk("abort:ok", CRC_OK, 1);
        chk("abort:calc", CRC_CALC, g);
        tick();
        tick();
        chk("abort:done_count", done_cnt - d0, 1);

        // Collision: word presented with CRC_VLD is dropped
        BURST_START = 1'b1;
        tick();
        BURST_START = 1'b0;
        g = SEED;
        for (int i = 0; i < 3; i++) begin
            w = 16'h1111 * 16'(i + 1);
            WORD_VLD = 1'b1;
            D = w;
            g = gold(g, w);
            tick();
        end
        D = 16'h1234;
        CRC_VLD = 1'b1;
        RX_CRC = g;
        tick();
        WORD_VLD = 1'b0;
        CRC_VLD = 1'b0;
        chk("coll:calc", CRC_CALC, g);
        tick();
        chk("coll:done", CRC_DONE, 1);
        chk("coll:ok", CRC_OK, 1);
        chk("coll:err", CRC_ERR, err_exp);

        // ERR_CLR alone clears sticky error without touching OK
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        err_exp = 1'b0;
        chk("clr:err", CRC_ERR, 0);
        chk("clr:ok", CRC_OK, 1);
        chk("clr:busy", BUSY, 0);

        // Random bursts against the polynomial-division model
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(0, 40);
            g = SEED;
            for (int i = 0; i < n; i++) begin
                sbuf[i] = 16'($urandom);
                g = gold(g, sbuf[i]);
            end
            bad = ($urandom_range(0, 2) == 0);
            clr = 1'($urandom_range(0, 1));
            rx = bad ? (g ^ (16'h0001 << $urandom_range(0, 15))) : g;
            run_burst($sformatf("rnd%0d", r), n, rx, clr, g, ~bad);
        end

        // Async reset mid-burst with the clock stopped
        sbuf[0] = 16'h5555;
        run_burst("pre_rst", 1, 16'h0000, 1'b0, gold(SEED, 16'h5555), 1'b0);
        BURST_START = 1'b1;
        tick();
        BURST_START = 1'b0;
        WORD_VLD = 1'b1;
        D = 16'hBEEF;
        tick();
        tick();
        WORD_VLD = 1'b0;
        @(negedge CLK4);
        #1;
        clk_run = 1'b0;
        RST_N = 1'b0;
        #2;
        err_exp = 1'b0;
        chk("arst:busy", BUSY, 0);
        chk("arst:calc", CRC_CALC, SEED);
        chk("arst:done", CRC_DONE, 0);
        chk("arst:ok", CRC_OK, 0);
        chk("arst:err", CRC_ERR, 0);
        #5;
        RST_N = 1'b1;
        clk_run = 1'b1;
        tick();
        d0 = done_cnt;
        WORD_VLD = 1'b1;
        D = 16'hABCD;
        CRC_VLD = 1'b1;
        RX_CRC = SEED;
        tick();
        WORD_VLD = 1'b0;
        CRC_VLD = 1'b0;
        tick();
        tick();
        chk("idle:no_done", done_cnt - d0, 0);
        chk("idle:calc", CRC_CALC, SEED);
        chk("idle:busy", BUSY, 0);

`ifdef UDMA_CRC_ERRCNT_EN
        // Saturating error counter
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        err_exp = 1'b0;
        chk("cnt:clr0", ERR_CNT, 0);
        for (int k = 1; k <= 5; k++) begin
            run_burst($sformatf("cnt%0d", k), 0, SEED ^ 16'h0001, 1'b0, SEED, 1'b0);
            chk($sformatf("cnt:val%0d", k), ERR_CNT, (k < 3) ? k : 3);
        end
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("cnt:clr", ERR_CNT, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_crc_check.md
Name: udma_crc_check

Overview:
Device-end Ultra DMA CRC checker. It sits between the UDMA data-word capture path and the task-file status logic.
- Accumulates CRC-16 over every 16-bit word strobed during a burst.
- At burst termination, compares the accumulated value against the CRC word received from the far end.
- Reports a per-burst match/mismatch and a sticky interface-CRC error.
- Uses the same polynomial (x^16+x^12+x^5+1), seed and parallel 16-bit update as the team's UDMA CRC generator, so generator and checker agree bit-for-bit.

Parameters:
SEED, 16'h4ABA, CRC register value loaded at burst start.
ERR_CNT_W, 8, width of the optional error counter.

Ports:
CLK4  in  1  system clock; all state changes on its rising edge.
RST_N  in  1  asynchronous active-low reset.
BURST_START  in  1  one-cycle pulse; arms checker and loads SEED.
WORD_VLD  in  1  D holds a valid data word this cycle.
D  in  16  data word.
CRC_VLD  in  1  one-cycle pulse; RX_CRC holds the received CRC word (burst termination).
RX_CRC  in  16  CRC word sent by the far end.
ERR_CLR  in  1  clears CRC_ERR (and ERR_CNT when compiled in).
BUSY  out  1  high in ACCUM.
CRC_CALC  out  16  running CRC register.
CRC_DONE  out  1  one-cycle pulse; compare result is valid.
CRC_OK  out  1  result of last compare; held until next compare or re-arm.
CRC_ERR  out  1  sticky mismatch flag.

Behaviour:
- Reset values (RST_N low, asynchronous): state IDLE, CRC_CALC=SEED, BUSY=0, CRC_DONE=0, CRC_OK=0, CRC_ERR=0, ERR_CNT=0. Reset mid-burst discards all partial state.
- States: IDLE, ACCUM, CHECK.
- IDLE:
  - BURST_START -> load SEED, go to ACCUM, clear CRC_OK.
  - WORD_VLD and CRC_VLD are ignored.
- ACCUM:
  - WORD_VLD -> CRC_CALC <= next(CRC_CALC, D) on the same edge; one word per cycle sustained; no bubbles required.
  - CRC_VLD -> latch RX_CRC and go to CHECK. A WORD_VLD in the same cycle is dropped (CRC_VLD has priority). CRC_CALC is not updated that cycle.
  - BURST_START in ACCUM aborts the burst: reload SEED, stay in ACCUM, no compare, no CRC_DONE.
- CHECK (exactly one cycle):
  - Compare latched RX_CRC with CRC_CALC.
  - CRC_DONE=1 for this cycle; CRC_OK=(equal).
  - On mismatch, CRC_ERR<=1.
  - Next state IDLE.
- Latency: CRC_VLD at edge n -> CRC_DONE/CRC_OK valid after edge n+1.
- Zero-length burst (BURST_START then CRC_VLD with no words) compares RX_CRC against SEED.
- ERR_CLR:
  - Clears CRC_ERR on the next edge.
  - If ERR_CLR coincides with a CHECK mismatch, the set wins (CRC_ERR stays 1).
  - ERR_CLR does not affect CRC_OK or state.
- CRC_CALC remains readable after DONE until the next BURST_START.
- next(): combinational 16-bit-parallel CRC-CCITT update, bit-identical to the team's UDMA generator equations.

Optional Feature:
UDMA_CRC_ERRCNT_EN
- Defined:
  - Adds output ERR_CNT[ERR_CNT_W-1:0].
  - Increments on each CHECK mismatch and saturates at all-ones (no wrap).
  - ERR_CLR zeroes it; simultaneous ERR_CLR and mismatch yields 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - UDMA_CRC_SEED (16'h4ABA);
  - the polynomial constant;
  - the state enum (IDLE/ACCUM/CHECK);
  - ERR_CNT_W default.
- One sub-module: udma_crc_next, a purely combinational next-CRC function (C[15:0], D[15:0] -> Q[15:0]). It is shared with the generator side so both ends use one implementation.

Test Plan:
1. Zero-length burst: BURST_START, then CRC_VLD with RX_CRC=16'h4ABA -> CRC_DONE one cycle later, CRC_OK=1, CRC_ERR=0. Repeat with RX_CRC=16'h4ABB -> CRC_OK=0, CRC_ERR=1.
2. 256-word burst, data 16'h0000..16'h00FF back-to-back -> CRC_CALC equals the bench golden model (serial CRC-CCITT, seed 4ABA); RX_CRC=golden gives CRC_OK=1. Repeat with one data bit flipped in word 37 -> CRC_OK=0, CRC_ERR=1.
3. Abort: BURST_START, 10 words, BURST_START, 5 words 16'hFFFF, correct CRC for those 5 words only -> CRC_OK=1, only one CRC_DONE pulse.
4. Collision: WORD_VLD=1, D=16'h1234 in the same cycle as CRC_VLD -> word ignored; CRC_OK reflects the CRC without 16'h1234. Separately, ERR_CLR coinciding with a mismatch -> CRC_ERR=1.
5. Async reset asserted mid-ACCUM (clock stopped) -> outputs go to reset values immediately. After release, CRC_VLD in IDLE produces no CRC_DONE.
6. With UDMA_CRC_ERRCNT_EN, ERR_CNT_W=2: 5 mismatching bursts -> ERR_CNT sequence 1,2,3,3,3; ERR_CLR -> 0.
